forth_uart_port: RTL and testbench

//  Memory-mapped 8N1 UART on the forth_cpu data bus, downstream of the top-level address decoder (ports region).

---
 rtl/forth_uart_port.sv | 221 ++++++++++++++++++++++
 tb/tb_forth_uart_port.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forth_uart_port.sv
// Memory-mapped 8N1 UART for the forth_cpu ports region: DATA/STATUS/CONTROL/DIVISOR registers,
// 8-deep TX FIFO, single-byte RX holding register and a registered level interrupt.
module forth_uart_port #(
  parameter int CLK_DIV   = 16,
  parameter int FIFO_BITS = 3
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        sel,
  input  logic        mem_valid,
  input  logic        mem_nwr,
  input  logic [1:0]  mem_address,
  input  logic [15:0] mem_data_in,
  output logic [15:0] mem_data_out,
  output logic        mem_ready,
  output logic        interrupt,
  output logic        tx,
  input  logic        rx
);

  localparam int DEPTH = 1 << FIFO_BITS;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  // Divisor values below 2 would leave no room for a mid-bit sample.
  function automatic logic [15:0] bit_len(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

  logic              accept, wr, data_rd, status_rd;
  logic [15:0]       divisor;
  logic [1:0]        control;
  logic [7:0]        fifo_mem [DEPTH];
  logic [FIFO_BITS:0] wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full, push_req, push_ok, pop;
  uart_state_t       tx_state, rx_state;
  logic [15:0]       tx_cnt, rx_cnt;
  logic [2:0]        tx_bit, rx_bit;
  logic [7:0]        tx_shift, rx_shift, rx_byte;
  logic              rx_s1, rx_s2, rx_d;
  logic              rxv, orun, ovf, ferr, rx_load, busy;
  logic [15:0]       status, rdata;

  assign accept     = sel & mem_valid & ~mem_ready;
  assign wr         = accept & ~mem_nwr;
  assign data_rd    = accept & mem_nwr & (mem_address == 2'd0);
  assign status_rd  = accept & mem_nwr & (mem_address == 2'd1);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_BITS] != rd_ptr[FIFO_BITS]) &&
                      (wr_ptr[FIFO_BITS-1:0] == rd_ptr[FIFO_BITS-1:0]);
  assign pop        = ~fifo_empty & ((tx_state == ST_IDLE) ||
                                     ((tx_state == ST_STOP) && (tx_cnt == 16'd0)));
  assign push_req   = wr & (mem_address == 2'd0);
  // A pop in the same cycle frees a slot, so a push onto a full FIFO still lands.
  assign push_ok    = push_req & (~fifo_full | pop);
  assign busy       = (tx_state != ST_IDLE);
  assign rx_load    = (rx_state == ST_STOP) && (rx_cnt == 16'd0);
  assign status     = {9'h0, ferr, ovf, orun, rxv, busy, fifo_full, fifo_empty};

  always_comb begin
    rdata = 16'h0;
    case (mem_address)
      2'd0: rdata = {8'h0, rx_byte};
      2'd1: rdata = status;
      2'd2: rdata = {14'h0, control};
      2'd3: rdata = divisor;
      default: rdata = 16'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr[FIFO_BITS-1:0]] <= mem_data_in[7:0];
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Transmit shifter: bit 0 goes out at the end of START, so DATA emits bits 1..7.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      tx_state <= ST_IDLE;
      tx       <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          if (pop) begin
            tx_state <= ST_START;
            tx       <= 1'b0;
            tx_cnt   <= bit_len(divisor) - 16'd1;
            tx_shift <= fifo_mem[rd_ptr[FIFO_BITS-1:0]];
          end
        end
        ST_START: begin
          if (tx_cnt == 16'd0) begin
            tx_state <= ST_DATA;
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= '0;
            tx_cnt   <= bit_len(divisor) - 16'd1;
          end else tx_cnt <= tx_cnt - 16'd1;
        end
        ST_DATA: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= bit_len(divisor) - 16'd1;
            if (tx_bit == 3'd7) begin
              tx_state <= ST_STOP;
              tx       <= 1'b1;
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 3'd1;
            end
          end else tx_cnt <= tx_cnt - 16'd1;
        end
        ST_STOP: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= bit_len(divisor) - 16'd1;
            if (pop) begin
              tx_state <= ST_START;
              tx       <= 1'b0;
              tx_shift <= fifo_mem[rd_ptr[FIFO_BITS-1:0]];
            end else begin
              tx_state <= ST_IDLE;
              tx       <= 1'b1;
            end
          end else tx_cnt <= tx_cnt - 16'd1;
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // Receiver: the half-bit delay from the falling edge lands later samples at mid-bit.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      case (rx_state)
        ST_IDLE: begin
          if (rx_d & ~rx_s2) begin
            rx_state <= ST_START;
            rx_cnt   <= (bit_len(divisor) >> 1) - 16'd1;
          end
        end
        ST_START: begin
          if (rx_cnt == 16'd0) begin
            if (rx_s2) rx_state <= ST_IDLE;
            else begin
              rx_state <= ST_DATA;
              rx_bit   <= '0;
              rx_cnt   <= bit_len(divisor) - 16'd1;
            end
          end else rx_cnt <= rx_cnt - 16'd1;
        end
        ST_DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= bit_len(divisor) - 16'd1;
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
            else rx_bit <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt - 16'd1;
        end
        ST_STOP: begin
          if (rx_cnt == 16'd0) rx_state <= ST_IDLE;
          else rx_cnt <= rx_cnt - 16'd1;
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  // Bus side: registers, sticky flags and the interrupt; a same-cycle set beats a read-clear.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      mem_ready    <= 1'b0;
      mem_data_out <= 16'h0;
      control      <= 2'b00;
      divisor      <= 16'(CLK_DIV);
      rx_byte      <= 8'h0;
      rxv          <= 1'b0;
      orun         <= 1'b0;
      ovf          <= 1'b0;
      ferr         <= 1'b0;
      interrupt    <= 1'b0;
    end else begin
      mem_ready    <= accept;
      mem_data_out <= (accept & mem_nwr) ? rdata : 16'h0;
      if (wr && mem_address == 2'd2) control <= mem_data_in[1:0];
      if (wr && mem_address == 2'd3) divisor <= mem_data_in;
      if (rx_load) begin
        rx_byte <= rx_shift;
        rxv     <= 1'b1;
      end else if (data_rd) rxv <= 1'b0;
      if (rx_load && rxv)       orun <= 1'b1;
      else if (status_rd)       orun <= 1'b0;
      if (push_req && !push_ok) ovf  <= 1'b1;
      else if (status_rd)       ovf  <= 1'b0;
      if (rx_load && !rx_s2)    ferr <= 1'b1;
      else if (status_rd)       ferr <= 1'b0;
      interrupt <= (control[0] & fifo_empty & ~busy) | (control[1] & rxv);
    end
  end

endmodule

// File: tb/tb_forth_uart_port.sv
// Bench for forth_uart_port: randomized bus/serial stimulus against a frame-level behavioural model.
module tb_forth_uart_port;
  localparam int CLK_DIV = 16;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        sel = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_nwr = 1'b1;
  logic [1:0]  mem_address = 2'd0;
  logic [15:0] mem_data_in = 16'h0;
  logic [15:0] mem_data_out;
  logic        mem_ready, interrupt, tx;
  logic        rx = 1'b1;

  int checks = 0;
  int passed = 0;
  logic [15:0] q;
  logic rdy1, rdy2;
  logic m_rxv, m_orun, m_ferr;
  logic [7:0] m_rxbyte;

  forth_uart_port #(.CLK_DIV(CLK_DIV), .FIFO_BITS(3)) dut (
    .clk(clk), .nreset(nreset), .sel(sel), .mem_valid(mem_valid), .mem_nwr(mem_nwr),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_ready(mem_ready), .interrupt(interrupt), .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rx_status();
    return {9'h0, m_ferr, 1'b0, m_orun, m_rxv, 3'b001};
  endfunction

  function automatic void model_reset();
    m_rxv = 1'b0; m_orun = 1'b0; m_ferr = 1'b0; m_rxbyte = 8'h0;
  endfunction

  // Called and returns on a falling edge; holds mem_valid across the ready pulse.
  task automatic bus(input logic nwr, input logic [1:0] a, input logic [15:0] d, output logic [15:0] rd);
    sel = 1'b1; mem_valid = 1'b1; mem_nwr = nwr; mem_address = a; mem_data_in = d;
    @(posedge clk); @(negedge clk);
    rd = mem_data_out; rdy1 = mem_ready;
    @(posedge clk); @(negedge clk);
    rdy2 = mem_ready;
    sel = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input int div, input logic stop);
    rx = 1'b0; repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i]; repeat (div) @(negedge clk);
    end
    rx = stop; repeat (div) @(negedge clk);
    rx = 1'b1; repeat (div) @(negedge clk);
    if (m_rxv) m_orun = 1'b1;
    m_rxv = 1'b1; m_rxbyte = b;
    if (!stop) m_ferr = 1'b1;
  endtask

  // Sample index k counts falling edges from the cycle after the first pop.
  task automatic watch_tx(input logic [7:0] b0, input logic [7:0] b1, input int n,
                          input int div, input int k0, input bit irq);
    int bad_k, bad_i;
    logic got, want, got_i, want_i;
    bad_k = -1; bad_i = -1; got = 1'b0; want = 1'b0; got_i = 1'b0; want_i = 1'b0;
    for (int k = k0; k < 10*n*div + 3; k++) begin
      int f, p;
      logic [7:0] bb;
      logic e;
      f = k / (10*div); p = (k % (10*div)) / div;
      bb = (f == 0) ? b0 : b1;
      if (f >= n) e = 1'b1;
      else if (p == 0) e = 1'b0;
      else if (p == 9) e = 1'b1;
      else e = bb[p-1];
      if (tx !== e && bad_k < 0) begin bad_k = k; got = tx; want = e; end
      if (irq && interrupt !== (k > 10*n*div) && bad_i < 0) begin
        bad_i = k; got_i = interrupt; want_i = (k > 10*n*div);
      end
      @(negedge clk);
    end
    checks++;
    if (bad_k >= 0) $display("FAIL tx_wave byte0=%h at cycle %0d got %b want %b", b0, bad_k, got, want);
    else passed++;
    if (irq) begin
      checks++;
      if (bad_i >= 0) $display("FAIL tx_irq at cycle %0d got %b want %b", bad_i, got_i, want_i);
      else passed++;
    end
  endtask

  task automatic test_reset();
    logic [15:0] exp_r [4];
    int bad;
    exp_r[0] = 16'h0000; exp_r[1] = 16'h0001; exp_r[2] = 16'h0000; exp_r[3] = 16'(CLK_DIV);
    nreset = 1'b0; repeat (3) @(negedge clk);
    checks++;
    if ({mem_ready, mem_data_out, interrupt, tx} !== {1'b0, 16'h0, 1'b0, 1'b1})
      $display("FAIL reset_outputs got %b want %b", {mem_ready, mem_data_out, interrupt, tx}, {1'b0, 16'h0, 1'b0, 1'b1});
    else passed++;
    nreset = 1'b1; model_reset(); @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      bus(1'b1, 2'(a), 16'h0, q);
      checks++;
      if (q !== exp_r[a]) $display("FAIL reset_reg%0d got %h want %h", a, q, exp_r[a]);
      else passed++;
      checks++;
      if ({rdy1, rdy2} !== 2'b10) $display("FAIL ready_pulse reg%0d got %b want 10", a, {rdy1, rdy2});
      else passed++;
    end
    checks++;
    if (tx !== 1'b1) $display("FAIL reset_tx got %b want 1", tx); else passed++;
    bad = 0;
    sel = 1'b0; mem_valid = 1'b1; mem_nwr = 1'b1;
    repeat (4) begin @(negedge clk); if (mem_ready !== 1'b0) bad++; end
    mem_valid = 1'b0;
    checks++;
    if (bad != 0) $display("FAIL nosel_ready got %0d pulses want 0", bad); else passed++;
  endtask

  task automatic test_regs();
    logic [15:0] d;
    bus(1'b0, 2'd2, 16'hFFFF, q); bus(1'b1, 2'd2, 16'h0, q);
    checks++;
    if (q !== 16'h0003) $display("FAIL control_rw got %h want 0003", q); else passed++;
    bus(1'b0, 2'd2, 16'h0000, q);
    d = 16'($urandom);
    bus(1'b0, 2'd3, d, q); bus(1'b1, 2'd3, 16'h0, q);
    checks++;
    if (q !== d) $display("FAIL divisor_rw got %h want %h", q, d); else passed++;
    bus(1'b0, 2'd1, 16'hFFFF, q); bus(1'b1, 2'd1, 16'h0, q);
    checks++;
    if (q !== 16'h0001) $display("FAIL status_ro got %h want 0001", q); else passed++;
  endtask

  task automatic test_tx_frame();
    bus(1'b0, 2'd3, 16'd4, q);
    bus(1'b0, 2'd0, 16'h0155, q);
    watch_tx(8'h55, 8'h00, 1, 4, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      int d;
      logic [7:0] b;
      d = $urandom_range(0, 6);
      b = 8'($urandom);
      bus(1'b0, 2'd3, 16'(d), q);
      bus(1'b0, 2'd0, {8'($urandom), b}, q);
      watch_tx(b, 8'h00, 1, (d < 2) ? 2 : d, 0, 1'b0);
    end
    bus(1'b1, 2'd1, 16'h0, q);
    checks++;
    if (q !== 16'h0001) $display("FAIL tx_done_status got %h want 0001", q); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    bus(1'b0, 2'd3, 16'd4, q);
    bus(1'b0, 2'd2, 16'h0001, q);
    bus(1'b0, 2'd0, {8'h00, a}, q);
    bus(1'b0, 2'd0, {8'h00, b}, q);
    watch_tx(a, b, 2, 4, 2, 1'b1);
    bus(1'b0, 2'd2, 16'h0000, q);
  endtask

  task automatic test_rx();
    logic [7:0] b1, b2;
    bus(1'b0, 2'd3, 16'd8, q);
    send_rx(8'hA3, 8, 1'b1);
    bus(1'b1, 2'd1, 16'h0, q);
    checks++;
    if (q !== rx_status()) $display("FAIL rx_status got %h want %h", q, rx_status()); else passed++;
    m_orun = 1'b0; m_ferr = 1'b0;
    bus(1'b1, 2'd0, 16'h0, q); m_rxv = 1'b0;
    checks++;
    if (q !== 16'h00A3) $display("FAIL rx_data got %h want 00A3", q); else passed++;
    bus(1'b1, 2'd1, 16'h0, q);
    checks++;
    if (q !== 16'h0001) $display("FAIL rx_cleared got %h want 0001", q); else passed++;
    b1 = 8'($urandom); b2 = 8'($urandom);
    send_rx(b1, 8, 1'b1); send_rx(b2, 8, 1'b1);
    bus(1'b1, 2'd1, 16'h0, q);
    checks++;
    if (q !== rx_status()) $display("FAIL rx_overrun got %h want %h", q, rx_status()); else passed++;
    m_orun = 1'b0; m_ferr = 1'b0;
    bus(1'b1, 2'd0, 16'h0, q); m_rxv = 1'b0;
    checks++;
    if (q !== {8'h00, b2}) $display("FAIL rx_overrun_data got %h want %h", q, {8'h00, b2}); else passed++;
    b1 = 8'($urandom);
    send_rx(b1, 8, 1'b0);
    bus(1'b1, 2'd1, 16'h0, q);
    checks++;
    if (q !== rx_status()) $display("FAIL rx_ferr got %h want %h", q, rx_status()); else passed++;
    m_orun = 1'b0; m_ferr = 1'b0;
    bus(1'b1, 2'd0, 16'h0, q); m_rxv = 1'b0;
    checks++;
    if (q !== {8'h00, b1}) $display("FAIL rx_ferr_data got %h want %h", q, {8'h00, b1}); else passed++;
    rx = 1'b0; @(negedge clk); rx = 1'b1; repeat (30) @(negedge clk);
    bus(1'b1, 2'd1, 16'h0, q);
    checks++;
    if (q !== 16'h0001) $display("FAIL rx_glitch got %h want 0001", q); else passed++;
    for (int i = 0; i < 4; i++) begin
      int d;
      d = $urandom_range(4, 12);
      b1 = 8'($urandom);
      bus(1'b0, 2'd3, 16'(d), q);
      send_rx(b1, d, ($urandom_range(0, 3) != 0));
      bus(1'b1, 2'd1, 16'h0, q);
      checks++;
      if (q !== rx_status()) $display("FAIL rx_rand_status div=%0d got %h want %h", d, q, rx_status()); else passed++;
      m_orun = 1'b0; m_ferr = 1'b0;
      bus(1'b1, 2'd0, 16'h0, q);
      checks++;
      if (q !== {8'h00, m_rxbyte}) $display("FAIL rx_rand_data div=%0d got %h want %h", d, q, {8'h00, m_rxbyte}); else passed++;
      m_rxv = 1'b0;
    end
    bus(1'b0, 2'd3, 16'd8, q);
    bus(1'b0, 2'd2, 16'h0002, q);
    send_rx(8'($urandom), 8, 1'b1);
    checks++;
    if (interrupt !== 1'b1) $display("FAIL rx_irq_set got %b want 1", interrupt); else passed++;
    bus(1'b1, 2'd0, 16'h0, q); m_rxv = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (interrupt !== 1'b0) $display("FAIL rx_irq_clear got %b want 0", interrupt); else passed++;
    bus(1'b0, 2'd2, 16'h0000, q);
  endtask

  task automatic test_reset_mid_rx();
    send_rx(8'h5A, 8, 1'b1);
    rx = 1'b0; repeat (8) @(negedge clk);
    rx = 1'b1; repeat (12) @(negedge clk);
    nreset = 1'b0; @(negedge clk);
    nreset = 1'b1; model_reset(); repeat (30) @(negedge clk);
    bus(1'b1, 2'd1, 16'h0, q);
    checks++;
    if (q !== 16'h0001) $display("FAIL rxreset_status got %h want 0001", q); else passed++;
    bus(1'b1, 2'd0, 16'h0, q);
    checks++;
    if (q !== 16'h0000) $display("FAIL rxreset_data got %h want 0000", q); else passed++;
  endtask

  task automatic test_fifo_and_reset();
    int queued;
    logic ovf;
    logic [15:0] want;
    int bad;
    bus(1'b0, 2'd3, 16'd100, q);
    queued = 0; ovf = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus(1'b0, 2'd0, 16'($urandom), q);
      if (i > 0) queued++;
    end
    want = {10'h0, ovf, 2'b00, 1'b1, (queued == 8), (queued == 0)};
    bus(1'b1, 2'd1, 16'h0, q);
    checks++;
    if (q !== want) $display("FAIL fifo_full got %h want %h", q, want); else passed++;
    bus(1'b0, 2'd0, 16'($urandom), q);
    if (queued == 8) ovf = 1'b1; else queued++;
    want = {10'h0, ovf, 2'b00, 1'b1, (queued == 8), (queued == 0)};
    bus(1'b1, 2'd1, 16'h0, q);
    checks++;
    if (q !== want) $display("FAIL fifo_ovf got %h want %h", q, want); else passed++;
    ovf = 1'b0;
    want = {10'h0, ovf, 2'b00, 1'b1, (queued == 8), (queued == 0)};
    bus(1'b1, 2'd1, 16'h0, q);
    checks++;
    if (q !== want) $display("FAIL fifo_ovf_clear got %h want %h", q, want); else passed++;
    checks++;
    if (tx !== 1'b0) $display("FAIL midframe_tx got %b want 0", tx); else passed++;
    nreset = 1'b0; @(negedge clk);
    checks++;
    if (tx !== 1'b1) $display("FAIL txreset_tx got %b want 1", tx); else passed++;
    nreset = 1'b1; model_reset();
    bad = 0;
    repeat (40) begin @(negedge clk); if (tx !== 1'b1) bad++; end
    checks++;
    if (bad != 0) $display("FAIL txreset_idle got %0d low cycles want 0", bad); else passed++;
    bus(1'b1, 2'd1, 16'h0, q);
    checks++;
    if (q !== 16'h0001) $display("FAIL txreset_status got %h want 0001", q); else passed++;
    bus(1'b1, 2'd3, 16'h0, q);
    checks++;
    if (q !== 16'(CLK_DIV)) $display("FAIL txreset_divisor got %h want %h", q, 16'(CLK_DIV)); else passed++;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_regs();
    test_tx_frame();
    test_back_to_back();
    test_rx();
    test_reset_mid_rx();
    test_fifo_and_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
